// File: rtl/hamming_secded_engine.sv
// SECDED decode co-processor: reads NUM_WORDS Hamming-coded words, writes corrected/flagged results.
// Optional HAMMING_ERR_COUNT_EN adds saturating single/double error counters (sgl_cnt, dbl_cnt).
module hamming_secded_engine #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  input  logic [7:0]    mem_rd_data,
  output logic [2:0]    dbg_state
`ifdef HAMMING_ERR_COUNT_EN
  ,
  output logic [3:0]    sgl_cnt,
  output logic [3:0]    dbl_cnt
`endif
);

  // Handshake: req is a start request sampled only in IDLE; done rises when the
  // last result byte is written and holds until the next accepted req clears it.
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  // Masks of code positions whose index has syndrome bit j set.
  localparam logic [15:0] M1 = 16'hAAAA;
  localparam logic [15:0] M2 = 16'hCCCC;
  localparam logic [15:0] M4 = 16'hF0F0;
  localparam logic [15:0] M8 = 16'hFF00;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_CAPT  = 3'd3,
    S_DEC   = 3'd4,
    S_WR_LO = 3'd5,
    S_WR_HI = 3'd6,
    S_ADV   = 3'd7
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_index;
  logic [7:0]    r_lo;
  logic [7:0]    r_hi;
  logic [15:0]   r_result;
  logic          r_done;

  logic [15:0]   w_word;
  logic [3:0]    w_syn;
  logic          w_par;
  logic [10:0]   w_data;
  logic          w_single;
  logic          w_double;
  logic [15:0]   w_result;
  logic          w_last;
  logic [AW-1:0] w_offs;
  logic [AW-1:0] w_src_lo;
  logic [AW-1:0] w_dst_lo;

  assign w_word   = {r_hi, r_lo};
  assign w_syn    = {^(w_word & M8), ^(w_word & M4), ^(w_word & M2), ^(w_word & M1)};
  assign w_par    = ^w_word;
  assign w_single = w_par;
  assign w_double = !w_par && (w_syn != 4'd0);
  assign w_result = {w_double, w_single, 3'b000, w_data};
  assign w_last   = (r_index == IW'(NUM_WORDS - 1));
  assign w_offs   = AW'({r_index, 1'b0});
  assign w_src_lo = AW'(SRC_BASE) + w_offs;
  assign w_dst_lo = AW'(DST_BASE) + w_offs;

  // Data bit j lives at code position 3, 5..7 or 9..15; flip it only when the
  // overall parity says single error and the syndrome points at that position.
  always_comb begin
    w_data = {w_word[15:9], w_word[7:5], w_word[3]};
    for (int j = 0; j < 11; j++) begin
      if (w_par && (w_syn == 4'((j == 0) ? 3 : ((j < 4) ? j + 4 : j + 5)))) begin
        w_data[j] = ~w_data[j];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The ADV cycle after WR_HI gives each word a fixed 7-cycle cadence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = req ? S_RD_LO : S_IDLE;
      S_RD_LO: w_next = S_RD_HI;
      S_RD_HI: w_next = S_CAPT;
      S_CAPT:  w_next = S_DEC;
      S_DEC:   w_next = S_WR_LO;
      S_WR_LO: w_next = S_WR_HI;
      S_WR_HI: w_next = S_ADV;
      S_ADV:   w_next = w_last ? S_IDLE : S_RD_LO;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b1;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;
    case (r_state)
      S_IDLE:  busy = 1'b0;
      S_RD_LO: mem_addr = w_src_lo;
      S_RD_HI: mem_addr = w_src_lo + AW'(1);
      S_WR_LO: begin
        mem_addr    = w_dst_lo;
        mem_wr_en   = 1'b1;
        mem_wr_data = r_result[7:0];
      end
      S_WR_HI: begin
        mem_addr    = w_dst_lo + AW'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = r_result[15:8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_index  <= '0;
      r_lo     <= 8'h00;
      r_hi     <= 8'h00;
      r_result <= 16'h0000;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_done  <= 1'b0;
            r_index <= '0;
          end
        end
        S_RD_HI: r_lo     <= mem_rd_data;
        S_CAPT:  r_hi     <= mem_rd_data;
        S_DEC:   r_result <= w_result;
        S_ADV: begin
          if (w_last) begin
            r_done <= 1'b1;
          end else begin
            r_index <= r_index + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HAMMING_ERR_COUNT_EN
  logic [3:0] r_sgl_cnt;
  logic [3:0] r_dbl_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sgl_cnt <= 4'd0;
      r_dbl_cnt <= 4'd0;
    end else if (r_state == S_IDLE && req) begin
      r_sgl_cnt <= 4'd0;
      r_dbl_cnt <= 4'd0;
    end else if (r_state == S_DEC) begin
      if (w_single && r_sgl_cnt != 4'hF) r_sgl_cnt <= r_sgl_cnt + 4'd1;
      if (w_double && r_dbl_cnt != 4'hF) r_dbl_cnt <= r_dbl_cnt + 4'd1;
    end
  end

  assign sgl_cnt = r_sgl_cnt;
  assign dbl_cnt = r_dbl_cnt;
`endif

  assign done      = r_done;
  assign dbg_state = r_state;

endmodule
